// File: rtl/exe_stage.sv
// Execute stage: unpacks the ID/EX bus, forwards operands from MEM/WB, runs the ALU,
// resolves branch/jump redirects and squashes the wrong-path slot behind a redirect.
module exe_stage #(
  parameter int IN_W  = 158,
  parameter int OUT_W = 72
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic [IN_W-1:0]  in_bus,
  input  logic [4:0]       rs,
  input  logic             stall,
  input  logic             mem_rw,
  input  logic [4:0]       mem_wreg,
  input  logic [31:0]      mem_data,
  input  logic             wb_rw,
  input  logic [4:0]       wb_wreg,
  input  logic [31:0]      wb_data,
  output logic [OUT_W-1:0] out_bus,
  output logic             redirect,
  output logic [31:0]      redirect_pc,
  output logic             flush_o
);

  localparam logic [0:0] RUN    = 1'b0;
  localparam logic [0:0] SQUASH = 1'b1;

  logic        reg_write, mem_to_reg, mem_write, branch_eq, jump, alu_src, reg_dst;
  logic [2:0]  alu_c;
  logic [4:0]  rt, rd, wreg;
  logic [15:0] imm16;
  logic [31:0] qa, qb, pc4;
  logic [25:0] adr26;

  assign reg_write  = in_bus[0];
  assign mem_to_reg = in_bus[1];
  assign mem_write  = in_bus[2];
  assign branch_eq  = in_bus[3];
  assign jump       = in_bus[4];
  assign alu_src    = in_bus[5];
  assign reg_dst    = in_bus[6];
  assign alu_c      = in_bus[9:7];
  assign rt         = in_bus[14:10];
  assign rd         = in_bus[19:15];
  assign imm16      = in_bus[35:20];
  assign qa         = in_bus[67:36];
  assign qb         = in_bus[99:68];
  assign pc4        = in_bus[131:100];
  assign adr26      = in_bus[157:132];

  logic [31:0] fwd_a, fwd_b, simm, alu_b, alu_res, target;
  logic        taken;
  logic [OUT_W-1:0] next_out;
  logic [0:0]  state;

  // MEM-stage result is younger than WB, so it wins; $zero is never forwarded
  always_comb begin
    fwd_a = qa;
    if (rs != 5'd0 && mem_rw && mem_wreg == rs)
      fwd_a = mem_data;
    else if (rs != 5'd0 && wb_rw && wb_wreg == rs)
      fwd_a = wb_data;
    fwd_b = qb;
    if (rt != 5'd0 && mem_rw && mem_wreg == rt)
      fwd_b = mem_data;
    else if (rt != 5'd0 && wb_rw && wb_wreg == rt)
      fwd_b = wb_data;
  end

  assign simm  = {{16{imm16[15]}}, imm16};
  assign alu_b = alu_src ? simm : fwd_b;
  assign wreg  = reg_dst ? rd : rt;

  always_comb begin
    alu_res = 32'd0;
    case (alu_c)
      3'b000: alu_res = fwd_a + alu_b;
      3'b001: alu_res = fwd_a - alu_b;
      3'b010: alu_res = fwd_a & alu_b;
      3'b011: alu_res = fwd_a | alu_b;
      3'b100: alu_res = fwd_a ^ alu_b;
      3'b101: alu_res = ~(fwd_a | alu_b);
      3'b110: alu_res = {31'd0, $signed(fwd_a) < $signed(alu_b)};
      3'b111: alu_res = {alu_b[15:0], 16'd0};
      default: alu_res = 32'd0;
    endcase
  end

  assign taken    = jump | (branch_eq & (fwd_a == fwd_b));
  assign target   = jump ? {pc4[31:28], adr26, 2'b00} : pc4 + {simm[29:0], 2'b00};
  assign next_out = {fwd_b, alu_res, wreg, mem_write, mem_to_reg, reg_write};
  assign flush_o  = redirect;

  // redirect defaults low every cycle so it can only ever be a one-cycle pulse
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      out_bus     <= '0;
      redirect    <= 1'b0;
      redirect_pc <= 32'd0;
      state       <= RUN;
    end else begin
      redirect <= 1'b0;
      if (!stall) begin
        case (state)
          RUN: begin
            out_bus <= next_out;
            if (taken) begin
              redirect    <= 1'b1;
              redirect_pc <= target;
              state       <= SQUASH;
            end
          end
          SQUASH: begin
            out_bus <= {next_out[OUT_W-1:3], 3'b000};
            state   <= RUN;
          end
          default: state <= RUN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: hand-computed vector table, directed redirect/stall/reset
// sequences, then randomized traffic against a behavioural model.
module tb_exe_stage;

  logic         clk = 1'b0;
  logic         clr_n;
  logic [157:0] in_bus;
  logic [4:0]   rs;
  logic         stall;
  logic         mem_rw;
  logic [4:0]   mem_wreg;
  logic [31:0]  mem_data;
  logic         wb_rw;
  logic [4:0]   wb_wreg;
  logic [31:0]  wb_data;
  logic [71:0]  out_bus;
  logic         redirect;
  logic [31:0]  redirect_pc;
  logic         flush_o;

  always #5 clk = ~clk;

  exe_stage dut (
    .clk(clk), .clr_n(clr_n), .in_bus(in_bus), .rs(rs), .stall(stall),
    .mem_rw(mem_rw), .mem_wreg(mem_wreg), .mem_data(mem_data),
    .wb_rw(wb_rw), .wb_wreg(wb_wreg), .wb_data(wb_data),
    .out_bus(out_bus), .redirect(redirect), .redirect_pc(redirect_pc), .flush_o(flush_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [71:0] exp_out;
  logic [71:0] exp_mask;
  logic        exp_redir;
  logic [31:0] exp_pc;
  bit          squashing;

  typedef struct {
    logic [157:0] bus;
    logic [4:0]   rs;
    logic         mrw;
    logic [4:0]   mwr;
    logic [31:0]  mdat;
    logic         wrw;
    logic [4:0]   wwr;
    logic [31:0]  wdat;
    logic [71:0]  exp;
  } vec_t;

  typedef struct {
    logic [71:0] out;
    bit          taken;
    logic [31:0] target;
  } model_t;

  function automatic logic [157:0] mk_bus(
    input logic rw, mtr, mw, beq, jmp, asrc, rdst, input logic [2:0] aluc,
    input logic [4:0] rt, rd, input logic [15:0] imm,
    input logic [31:0] qa, qb, pc4, input logic [25:0] adr);
    return {adr, pc4, qb, qa, imm, rd, rt, aluc, rdst, asrc, jmp, beq, mw, mtr, rw};
  endfunction

  function automatic logic [31:0] pick(input logic [4:0] r, input logic [31:0] q);
    if (r != 0 && mem_rw && mem_wreg == r) return mem_data;
    if (r != 0 && wb_rw && wb_wreg == r) return wb_data;
    return q;
  endfunction

  // Plain-arithmetic reading of the execute rules, evaluated on the currently driven inputs
  function automatic model_t ref_model();
    model_t m;
    logic signed [15:0] imm_s;
    int          simm, sa, sb;
    int unsigned a, b, bv, res;
    logic [31:0] pc4;
    imm_s = in_bus[35:20];
    simm  = imm_s;
    a     = pick(rs, in_bus[67:36]);
    b     = pick(in_bus[14:10], in_bus[99:68]);
    bv    = in_bus[5] ? simm : b;
    sa    = a;
    sb    = bv;
    case (in_bus[9:7])
      3'd0: res = a + bv;
      3'd1: res = a - bv;
      3'd2: res = a & bv;
      3'd3: res = a | bv;
      3'd4: res = a ^ bv;
      3'd5: res = ~(a | bv);
      3'd6: res = (sa < sb) ? 1 : 0;
      default: res = bv * 65536;
    endcase
    pc4      = in_bus[131:100];
    m.out    = {b, res, (in_bus[6] ? in_bus[19:15] : in_bus[14:10]), in_bus[2:0]};
    m.taken  = in_bus[4] || (in_bus[3] && a == b);
    m.target = in_bus[4] ? {pc4[31:28], in_bus[157:132], 2'b00} : pc4 + simm * 4;
    return m;
  endfunction

  task automatic model_reset();
    exp_out   = '0;
    exp_mask  = '1;
    exp_redir = 1'b0;
    exp_pc    = '0;
    squashing = 1'b0;
  endtask

  task automatic model_step();
    model_t m;
    exp_redir = 1'b0;
    if (!stall) begin
      m = ref_model();
      if (squashing) begin
        exp_out   = {m.out[71:3], 3'b000};
        exp_mask  = 72'h7;
        squashing = 1'b0;
      end else begin
        exp_out  = m.out;
        exp_mask = '1;
        if (m.taken) begin
          exp_redir = 1'b1;
          exp_pc    = m.target;
          squashing = 1'b1;
        end
      end
    end
  endtask

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  task automatic check_output(input string nm);
    chk({nm, ".out_bus"}, out_bus & exp_mask, exp_out & exp_mask);
    chk({nm, ".redirect"}, {71'd0, redirect}, {71'd0, exp_redir});
    chk({nm, ".redirect_pc"}, {40'd0, redirect_pc}, {40'd0, exp_pc});
    chk({nm, ".flush_o"}, {71'd0, flush_o}, {71'd0, exp_redir});
  endtask

  task automatic apply_stimulus(input logic [157:0] bus, input logic [4:0] r, input logic st);
    in_bus = bus;
    rs     = r;
    stall  = st;
  endtask

  task automatic no_fwd();
    mem_rw = 0; mem_wreg = 0; mem_data = 0;
    wb_rw = 0; wb_wreg = 0; wb_data = 0;
  endtask

  task automatic cycle(input string nm);
    model_step();
    @(posedge clk);
    #1;
    check_output(nm);
  endtask

  vec_t vt[16];

  initial begin
    vt[0]  = '{mk_bus(1,0,0,0,0,0,1,3'd0,5'd0,5'd3,16'd0,32'd5,32'd7,32'd0,26'd0), 5'd0,
               0,5'd0,32'd0, 0,5'd0,32'd0, {32'd7, 32'd12, 5'd3, 3'b001}};
    vt[1]  = '{mk_bus(1,0,0,0,0,1,0,3'd0,5'd6,5'd0,16'd1,32'h99,32'd5,32'd0,26'd0), 5'd4,
               1,5'd4,32'h10, 1,5'd4,32'h20, {32'd5, 32'h11, 5'd6, 3'b001}};
    vt[2]  = '{mk_bus(1,0,0,0,0,1,0,3'd0,5'd6,5'd0,16'd1,32'h99,32'd5,32'd0,26'd0), 5'd0,
               1,5'd4,32'h10, 1,5'd4,32'h20, {32'd5, 32'h9A, 5'd6, 3'b001}};
    vt[3]  = '{mk_bus(1,0,0,0,0,1,0,3'd0,5'd2,5'd0,16'd3,32'h55,32'h66,32'd0,26'd0), 5'd2,
               0,5'd0,32'd0, 1,5'd2,32'h100, {32'h100, 32'h103, 5'd2, 3'b001}};
    vt[4]  = '{mk_bus(1,0,0,0,0,0,1,3'd6,5'd0,5'd8,16'd0,32'hFFFFFFFF,32'd1,32'd0,26'd0), 5'd0,
               0,5'd0,32'd0, 0,5'd0,32'd0, {32'd1, 32'd1, 5'd8, 3'b001}};
    vt[5]  = '{mk_bus(1,0,0,0,0,1,0,3'd7,5'd9,5'd0,16'h1234,32'd0,32'h77,32'd0,26'd0), 5'd0,
               0,5'd0,32'd0, 0,5'd0,32'd0, {32'h77, 32'h12340000, 5'd9, 3'b001}};
    vt[6]  = '{mk_bus(1,0,0,0,0,0,1,3'd1,5'd0,5'd10,16'd0,32'd0,32'd1,32'd0,26'd0), 5'd0,
               0,5'd0,32'd0, 0,5'd0,32'd0, {32'd1, 32'hFFFFFFFF, 5'd10, 3'b001}};
    vt[7]  = '{mk_bus(1,0,0,0,0,0,1,3'd2,5'd0,5'd11,16'd0,32'hF0F0,32'hFF00,32'd0,26'd0), 5'd0,
               0,5'd0,32'd0, 0,5'd0,32'd0, {32'hFF00, 32'hF000, 5'd11, 3'b001}};
    vt[8]  = '{mk_bus(1,0,0,0,0,0,1,3'd3,5'd0,5'd11,16'd0,32'hF0F0,32'hFF00,32'd0,26'd0), 5'd0,
               0,5'd0,32'd0, 0,5'd0,32'd0, {32'hFF00, 32'hFFF0, 5'd11, 3'b001}};
    vt[9]  = '{mk_bus(1,0,0,0,0,0,1,3'd4,5'd0,5'd11,16'd0,32'hF0F0,32'hFF00,32'd0,26'd0), 5'd0,
               0,5'd0,32'd0, 0,5'd0,32'd0, {32'hFF00, 32'h0FF0, 5'd11, 3'b001}};
    vt[10] = '{mk_bus(1,0,0,0,0,0,1,3'd5,5'd0,5'd12,16'd0,32'd0,32'd0,32'd0,26'd0), 5'd0,
               0,5'd0,32'd0, 0,5'd0,32'd0, {32'd0, 32'hFFFFFFFF, 5'd12, 3'b001}};
    vt[11] = '{mk_bus(0,0,1,0,0,1,0,3'd0,5'd5,5'd0,16'hFFFC,32'h1000,32'hABCD,32'd0,26'd0), 5'd0,
               0,5'd0,32'd0, 0,5'd0,32'd0, {32'hABCD, 32'hFFC, 5'd5, 3'b100}};
    vt[12] = '{158'd0, 5'd0, 0,5'd0,32'd0, 0,5'd0,32'd0, 72'd0};
    vt[13] = '{mk_bus(1,0,0,0,0,0,0,3'd0,5'd0,5'd0,16'd0,32'd3,32'd4,32'd0,26'd0), 5'd0,
               1,5'd0,32'hDEAD, 1,5'd0,32'hBEEF, {32'd4, 32'd7, 5'd0, 3'b001}};
    vt[14] = '{mk_bus(1,0,0,0,0,0,0,3'd0,5'd7,5'd0,16'd0,32'd1,32'd99,32'd0,26'd0), 5'd0,
               1,5'd7,32'h10, 1,5'd7,32'h20, {32'h10, 32'h11, 5'd7, 3'b001}};
    vt[15] = '{mk_bus(1,1,0,0,0,1,0,3'd0,5'd3,5'd0,16'd8,32'h200,32'd0,32'd0,26'd0), 5'd0,
               0,5'd0,32'd0, 0,5'd0,32'd0, {32'd0, 32'h208, 5'd3, 3'b011}};

    // Reset state
    clr_n = 1'b0;
    no_fwd();
    apply_stimulus('0, 5'd0, 1'b0);
    model_reset();
    #2;
    check_output("reset");
    @(negedge clk);
    clr_n = 1'b1;

    // Vector table: straight-line ALU/forwarding cases
    for (int i = 0; i < 16; i++) begin
      apply_stimulus(vt[i].bus, vt[i].rs, 1'b0);
      mem_rw = vt[i].mrw; mem_wreg = vt[i].mwr; mem_data = vt[i].mdat;
      wb_rw = vt[i].wrw; wb_wreg = vt[i].wwr; wb_data = vt[i].wdat;
      model_step();
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d.out_bus", i), out_bus, vt[i].exp);
      chk($sformatf("vec%0d.redirect", i), {71'd0, redirect}, 72'd0);
    end
    no_fwd();

    // Taken BranchEq, then a MemWrite slot that must be squashed
    apply_stimulus(mk_bus(0,0,0,1,0,0,0,3'd1,5'd2,5'd0,16'hFFFF,32'd9,32'd9,32'h100,26'd0), 5'd1, 1'b0);
    cycle("beq");
    chk("beq.pulse", {71'd0, redirect}, 72'd1);
    chk("beq.target", {40'd0, redirect_pc}, {40'd0, 32'hFC});
    apply_stimulus(mk_bus(1,0,1,0,1,0,0,3'd0,5'd2,5'd0,16'd0,32'd1,32'd2,32'h104,26'h55), 5'd1, 1'b0);
    cycle("beq_squash");
    chk("beq_squash.flags", {69'd0, out_bus[2:0]}, 72'd0);
    chk("beq_squash.one_pulse", {71'd0, redirect}, 72'd0);
    apply_stimulus('0, 5'd0, 1'b0);
    cycle("bubble");

    // Jump, with a second jump sitting in the squash slot
    apply_stimulus(mk_bus(0,0,0,0,1,0,0,3'd0,5'd0,5'd0,16'd0,32'd0,32'd0,32'h40000010,26'h10), 5'd0, 1'b0);
    cycle("jump");
    chk("jump.target", {40'd0, redirect_pc}, {40'd0, 32'h40000040});
    apply_stimulus(mk_bus(1,0,0,0,1,0,0,3'd0,5'd0,5'd0,16'd0,32'd0,32'd0,32'h40000014,26'h20), 5'd0, 1'b0);
    cycle("jump_squash");
    chk("jump_squash.no_pulse", {71'd0, redirect}, 72'd0);
    apply_stimulus('0, 5'd0, 1'b0);
    cycle("bubble2");

    // Stall holds a pending branch for three cycles, then also inside SQUASH
    apply_stimulus(mk_bus(1,0,0,0,0,0,1,3'd0,5'd0,5'd4,16'd0,32'd1,32'd2,32'd0,26'd0), 5'd0, 1'b0);
    cycle("pre_stall");
    apply_stimulus(mk_bus(0,0,0,1,0,0,0,3'd0,5'd6,5'd0,16'd4,32'd5,32'd5,32'h200,26'd0), 5'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle("stall_run");
      chk("stall_run.hold", out_bus, {32'd2, 32'd3, 5'd4, 3'b001});
      chk("stall_run.no_pulse", {71'd0, redirect}, 72'd0);
    end
    stall = 1'b0;
    cycle("stall_release");
    chk("stall_release.target", {40'd0, redirect_pc}, {40'd0, 32'h210});
    apply_stimulus(mk_bus(1,0,1,0,1,0,0,3'd0,5'd1,5'd0,16'd0,32'd0,32'd0,32'h0,26'h3), 5'd0, 1'b1);
    cycle("stall_squash");
    stall = 1'b0;
    cycle("squash_after_stall");

    // Reset pulse while a redirect is live, then a branch from RUN
    apply_stimulus(mk_bus(0,0,0,0,1,0,0,3'd0,5'd0,5'd0,16'd0,32'd0,32'd0,32'h80000000,26'h7), 5'd0, 1'b0);
    cycle("jump_before_reset");
    clr_n = 1'b0;
    model_reset();
    #1;
    check_output("mid_reset");
    @(negedge clk);
    clr_n = 1'b1;
    apply_stimulus(mk_bus(0,0,0,1,0,0,0,3'd0,5'd0,5'd0,16'd2,32'd0,32'd0,32'h300,26'd0), 5'd0, 1'b0);
    cycle("beq_after_reset");
    chk("beq_after_reset.pulse", {71'd0, redirect}, 72'd1);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic [31:0] qa;
      qa = $urandom;
      apply_stimulus(mk_bus($urandom_range(0,1), $urandom_range(0,1), $urandom_range(0,1),
                            ($urandom_range(0,3) == 0), ($urandom_range(0,7) == 0),
                            $urandom_range(0,1), $urandom_range(0,1), 3'($urandom_range(0,7)),
                            5'($urandom_range(0,3)), 5'($urandom_range(0,3)), 16'($urandom),
                            qa, ($urandom_range(0,2) == 0) ? qa : 32'($urandom),
                            32'($urandom), 26'($urandom)),
                     5'($urandom_range(0,3)), ($urandom_range(0,4) == 0));
      mem_rw = $urandom_range(0,1); mem_wreg = 5'($urandom_range(0,3)); mem_data = $urandom;
      wb_rw = $urandom_range(0,1); wb_wreg = 5'($urandom_range(0,3)); wb_data = $urandom;
      cycle("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
